// File: rtl/seq_restoring_div.sv
// seq_restoring_div: iterative unsigned restoring divider, one quotient bit per clock.
// Operands enter and results leave on valid/ready channels; B == 0 short-circuits to DONE.
module seq_restoring_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH:0]   pr;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   r;
    logic [WIDTH+1:0] d;
    logic             neg;

    // Single subtract/restore slice shared by every iteration.
    always_comb begin
        r   = {pr[WIDTH-1:0], a_reg[cnt]};
        d   = {1'b0, r} - {2'b00, b_reg};
        neg = d[WIDTH+1];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            pr          <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg       <= dividend;
                        b_reg       <= divisor;
                        pr          <= '0;
                        cnt         <= CW'(WIDTH - 1);
                        div_by_zero <= 1'b0;
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            state       <= DONE;
                        end else begin
                            quotient <= '0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    quotient[cnt] <= ~neg;
                    pr            <= neg ? r : d[WIDTH:0];
                    if (cnt == '0) begin
                        remainder <= neg ? r[WIDTH-1:0] : d[WIDTH-1:0];
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // PR stays below B, so its top bit and the non-negative difference's top bit are always zero.
    pr_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        (pr[WIDTH] == 1'b0) && (neg || (d[WIDTH] == 1'b0)));

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed and randomized checks for seq_restoring_div at WIDTH = 8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_restoring_div;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_bad = 0;

    seq_restoring_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           stall;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Caller sits just after a falling edge; returns just after the falling edge
    // that follows the accept edge.
    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // lat counts rising edges after the accept edge until out_valid is seen.
    task automatic wait_done(inout int lat);
        while (!out_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_op(input logic [W-1:0] q_e, input logic [W-1:0] r_e,
                             input logic dz_e, input int stall);
        chk("quotient", 32'(quotient), 32'(q_e));
        chk("remainder", 32'(remainder), 32'(r_e));
        chk("div_by_zero", 32'(div_by_zero), 32'(dz_e));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_quotient", 32'(quotient), 32'(q_e));
            chk("stall_remainder", 32'(remainder), 32'(r_e));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_out_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q_e, input logic [W-1:0] r_e,
                          input logic dz_e, input int stall);
        int lat;
        accept(a, b);
        lat = 0;
        wait_done(lat);
        // Divide-by-zero result is visible in the cycle right after accept.
        chk("latency", 32'(lat), dz_e ? 32'd0 : 32'(W));
        finish_op(q_e, r_e, dz_e, stall);
    endtask

    initial begin
        int lat;
        logic [W-1:0] ra, rb, rq, rr;

        tbl[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   dz: 1'b0, stall: 0};
        tbl[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0, stall: 0};
        tbl[2] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dz: 1'b0, stall: 0};
        tbl[3] = '{a: 8'd37,  b: 8'd0,   q: 8'hFF,  r: 8'd37,  dz: 1'b1, stall: 0};
        tbl[4] = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,   dz: 1'b0, stall: 0};
        tbl[5] = '{a: 8'd200, b: 8'd13,  q: 8'd15,  r: 8'd5,   dz: 1'b0, stall: 5};
        tbl[6] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dz: 1'b0, stall: 0};
        tbl[7] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0, stall: 1};
        tbl[8] = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, dz: 1'b0, stall: 0};
        tbl[9] = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0,   dz: 1'b0, stall: 2};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_div_by_zero", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].stall);

        // Busy rejection: a pulse during CALC must not disturb 50 / 6.
        accept(8'd50, 8'd6);
        lat = 0;
        repeat (2) begin
            @(negedge clk);
            lat++;
        end
        dividend = 8'd1;
        divisor  = 8'd1;
        in_valid = 1'b1;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        lat++;
        in_valid = 1'b0;
        wait_done(lat);
        chk("busy_latency", 32'(lat), 32'(W));
        finish_op(8'd8, 8'd2, 1'b0, 0);

        // Reset after four steps of 99 / 10 abandons the operation.
        accept(8'd99, 8'd10);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_div_by_zero", 32'(div_by_zero), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_hold_out_valid", 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            chk("postrst_no_out_valid", 32'(out_valid), 32'd0);
        end
        run_op(8'd99, 8'd10, 8'd9, 8'd9, 1'b0, 0);

        // Random operands against a reference quotient/remainder.
        for (int i = 0; i < 400; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (rb == 0) begin
                rq = 8'hFF;
                rr = ra;
            end else begin
                rq = ra / rb;
                rr = ra % rb;
            end
            run_op(ra, rb, rq, rr, rb == 0, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
